// File: rtl/send_arb.sv
// send_arb: shared SEND engine for the four-PU system.
// Each PU raises a one-cycle SEND strobe. The engine latches the strobe into a
// per-PU pending slot, picks one pending PU and streams its data-memory words
// onto a ready/valid link. Each word is tagged with the destination port and
// the source PU.
// Optional build macro: SEND_RR_EN selects round-robin arbitration. Without it,
// arbitration is fixed priority and the lowest pending index wins.
module send_arb #(
    parameter int NPU = 4,
    parameter int DW  = 16,
    parameter int AW  = 8,
    parameter int PW  = 4,
    localparam int SW = (NPU > 32'sd1) ? $clog2(NPU) : 32'sd1
) (
    input  logic              ck,
    input  logic              rst_n,
    input  logic [NPU-1:0]    req,
    input  logic [NPU*AW-1:0] req_ad,
    input  logic [NPU*AW-1:0] req_sz,
    input  logic [NPU*PW-1:0] req_pt,
    output logic [NPU-1:0]    busy,
    output logic [NPU-1:0]    ack,
    output logic [NPU-1:0]    rd_en,
    output logic [AW-1:0]     rd_ad,
    input  logic [NPU*DW-1:0] rd_q,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DW-1:0]     out_data,
    output logic [PW-1:0]     out_port,
    output logic [SW-1:0]     out_src,
    output logic              out_last
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_LAT  = 3'd2;
    localparam logic [2:0] S_XFER = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [AW-1:0] AD_ONE = {{(AW-1){1'b0}}, 1'b1};

    // One-hot decode of a PU index.
    function automatic logic [NPU-1:0] onehot(input logic [SW-1:0] ix);
        logic [NPU-1:0] v;
        v     = '0;
        v[ix] = 1'b1;
        return v;
    endfunction

    logic [2:0]     st_r;
    logic [NPU-1:0] pend_r;
    logic [AW-1:0]  sh_ad_r [NPU];
    logic [AW-1:0]  sh_sz_r [NPU];
    logic [PW-1:0]  sh_pt_r [NPU];

    logic [SW-1:0]  own_r;
    logic [AW-1:0]  cur_ad_r;
    logic [AW-1:0]  cnt_r;
    logic [PW-1:0]  port_r;
`ifdef SEND_RR_EN
    logic [SW-1:0]  last_r;
`endif

    logic [NPU-1:0] ack_r;
    logic [NPU-1:0] rd_en_r;
    logic [AW-1:0]  rd_ad_r;
    logic           out_vld_r;
    logic [DW-1:0]  out_data_r;
    logic [PW-1:0]  out_port_r;
    logic [SW-1:0]  out_src_r;
    logic           out_last_r;

    logic [NPU-1:0] done_hit_s;
    logic [NPU-1:0] take_s;
    logic [SW-1:0]  win_s;
    logic           win_vld_s;
    int             base_s;
    int             idx_s;
    logic [SW-1:0]  idx_sel_s;
    logic [DW-1:0]  rdq_own_s;
    logic [AW-1:0]  cur_ad_inc_s;

    // Request acceptance. A PU whose transfer is completing this cycle may
    // queue its next request at once.
    always_comb begin
        done_hit_s = '0;
        if (st_r == S_DONE) begin
            done_hit_s = onehot(own_r);
        end else begin
            done_hit_s = '0;
        end
        take_s = req & (~pend_r | done_hit_s);
    end

    // Winner selection among pending PUs, scanning from the arbitration base.
    always_comb begin
        win_s     = '0;
        win_vld_s = 1'b0;
        idx_s     = 32'sd0;
        idx_sel_s = '0;
`ifdef SEND_RR_EN
        base_s    = int'(last_r) + 32'sd1;
`else
        base_s    = 32'sd0;
`endif
        for (int k = 32'sd0; k < NPU; k++) begin
            idx_s     = (base_s + k) % NPU;
            idx_sel_s = idx_s[SW-1:0];
            if (!win_vld_s && pend_r[idx_sel_s]) begin
                win_s     = idx_sel_s;
                win_vld_s = 1'b1;
            end else begin
                win_s     = win_s;
                win_vld_s = win_vld_s;
            end
        end
    end

    // Select the owner's read data and form the next word address.
    always_comb begin
        rdq_own_s = '0;
        for (int i = 32'sd0; i < NPU; i++) begin
            if (own_r == i[SW-1:0]) begin
                rdq_own_s = rd_q[i*DW +: DW];
            end else begin
                rdq_own_s = rdq_own_s;
            end
        end
        cur_ad_inc_s = cur_ad_r + AD_ONE;
    end

    // Pending flags and per-PU shadow copies of the SEND operands.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= '0;
            for (int i = 32'sd0; i < NPU; i++) begin
                sh_ad_r[i] <= '0;
                sh_sz_r[i] <= '0;
                sh_pt_r[i] <= '0;
            end
        end else begin
            for (int i = 32'sd0; i < NPU; i++) begin
                if (take_s[i]) begin
                    pend_r[i]  <= 1'b1;
                    sh_ad_r[i] <= req_ad[i*AW +: AW];
                    sh_sz_r[i] <= req_sz[i*AW +: AW];
                    sh_pt_r[i] <= req_pt[i*PW +: PW];
                end else if (done_hit_s[i]) begin
                    pend_r[i] <= 1'b0;
                end
            end
        end
    end

    // Transfer sequencer: grant, read, latch word, link handshake, complete.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            st_r       <= S_IDLE;
            own_r      <= '0;
            cur_ad_r   <= '0;
            cnt_r      <= '0;
            port_r     <= '0;
            ack_r      <= '0;
            rd_en_r    <= '0;
            rd_ad_r    <= '0;
            out_vld_r  <= 1'b0;
            out_data_r <= '0;
            out_port_r <= '0;
            out_src_r  <= '0;
            out_last_r <= 1'b0;
`ifdef SEND_RR_EN
            last_r     <= SW'(NPU - 32'sd1);
`endif
        end else begin
            ack_r   <= '0;
            rd_en_r <= '0;
            case (st_r)
                S_IDLE: begin
                    if (win_vld_s) begin
                        own_r    <= win_s;
                        cur_ad_r <= sh_ad_r[win_s];
                        cnt_r    <= sh_sz_r[win_s];
                        port_r   <= sh_pt_r[win_s];
`ifdef SEND_RR_EN
                        last_r   <= win_s;
`endif
                        if (sh_sz_r[win_s] == {AW{1'b0}}) begin
                            st_r  <= S_DONE;
                            ack_r <= onehot(win_s);
                        end else begin
                            st_r    <= S_RD;
                            rd_en_r <= onehot(win_s);
                            rd_ad_r <= sh_ad_r[win_s];
                        end
                    end
                end
                S_RD: begin
                    st_r <= S_LAT;
                end
                S_LAT: begin
                    out_data_r <= rdq_own_s;
                    out_vld_r  <= 1'b1;
                    out_last_r <= (cnt_r == AD_ONE);
                    out_port_r <= port_r;
                    out_src_r  <= own_r;
                    st_r       <= S_XFER;
                end
                S_XFER: begin
                    if (out_rdy) begin
                        out_vld_r  <= 1'b0;
                        out_last_r <= 1'b0;
                        cnt_r      <= cnt_r - AD_ONE;
                        cur_ad_r   <= cur_ad_inc_s;
                        if (cnt_r == AD_ONE) begin
                            st_r  <= S_DONE;
                            ack_r <= onehot(own_r);
                        end else begin
                            st_r    <= S_RD;
                            rd_en_r <= onehot(own_r);
                            rd_ad_r <= cur_ad_inc_s;
                        end
                    end
                end
                S_DONE: begin
                    st_r <= S_IDLE;
                end
                default: begin
                    st_r <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = pend_r;
    assign ack      = ack_r;
    assign rd_en    = rd_en_r;
    assign rd_ad    = rd_ad_r;
    assign out_vld  = out_vld_r;
    assign out_data = out_data_r;
    assign out_port = out_port_r;
    assign out_src  = out_src_r;
    assign out_last = out_last_r;

endmodule
